// File: rtl/hit_detector.sv
// hit_detector: conditions the raw player sensor (two-flop synchroniser,
// debounce, rising-edge detect), classifies each press as hit or miss,
// measures reaction time and offers one result per press to the scorer over
// a valid/ready handshake.
// Optional feature macro: MISS_COUNT_EN adds the saturating miss_count output.
module hit_detector #(
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int RT_WIDTH        = 8
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                sensor_raw,
   input  logic                target_up,
   output logic                hit_valid,
   input  logic                hit_ready,
   output logic                hit_on_target,
   output logic [RT_WIDTH-1:0] hit_rt
`ifdef MISS_COUNT_EN
   ,
   output logic [7:0]          miss_count
`endif
);

   localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [DB_W-1:0]     DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [RT_WIDTH-1:0] RT_MAX  = {RT_WIDTH{1'b1}};

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_ARMED     = 3'd1,
      ST_HELD_HIT  = 3'd2,
      ST_HELD_MISS = 3'd3,
      ST_LOCKOUT   = 3'd4
   } state_t;

   logic                sync1_q, sync2_q;
   logic                stable_q, stable_prev_q;
   logic [DB_W-1:0]     db_cnt_q;
   logic                target_q;
   logic [RT_WIDTH-1:0] rt_cnt_q, rt_cnt_d;
   state_t              state_q, state_d;
   logic                valid_q, valid_d;
   logic                on_q, on_d;
   logic [RT_WIDTH-1:0] rt_q, rt_d;
   logic                press_s, t_rise_s, xfer_s, rt_count_en_s;

   assign press_s       = stable_q & ~stable_prev_q;
   assign t_rise_s      = target_up & ~target_q;
   assign xfer_s        = valid_q & hit_ready;
   // After a target rise during HELD_MISS the reaction clock must already run.
   assign rt_count_en_s = (state_q == ST_ARMED) | ((state_q == ST_HELD_MISS) & target_q);

   // Synchronise the raw sensor and accept a level change only after it has held for DEBOUNCE_CYCLES cycles.
   always_ff @(posedge clk) begin
      if (reset) begin
         sync1_q       <= 1'b0;
         sync2_q       <= 1'b0;
         stable_q      <= 1'b0;
         stable_prev_q <= 1'b0;
         db_cnt_q      <= {DB_W{1'b0}};
      end else begin
         sync1_q       <= sensor_raw;
         sync2_q       <= sync1_q;
         stable_prev_q <= stable_q;
         if (sync2_q != stable_q) begin
            if (db_cnt_q == DB_LAST) begin
               stable_q <= sync2_q;
               db_cnt_q <= {DB_W{1'b0}};
            end else begin
               db_cnt_q <= db_cnt_q + DB_W'(1);
            end
         end else begin
            db_cnt_q <= {DB_W{1'b0}};
         end
      end
   end

   // Reaction-time counter: restart on every target rise, count while waiting for a press, saturate.
   always_comb begin
      rt_cnt_d = rt_cnt_q;
      if (t_rise_s) begin
         rt_cnt_d = {RT_WIDTH{1'b0}};
      end else if (rt_count_en_s && (rt_cnt_q != RT_MAX)) begin
         rt_cnt_d = rt_cnt_q + RT_WIDTH'(1);
      end else begin
         rt_cnt_d = rt_cnt_q;
      end
   end

   // Scoring FSM next state and result loading; a press and target fall in the same cycle still scores.
   always_comb begin
      state_d = state_q;
      on_d    = on_q;
      rt_d    = rt_q;
      case (state_q)
         ST_IDLE: begin
            if (t_rise_s) begin
               state_d = ST_ARMED;
            end else if (press_s && !target_up) begin
               state_d = ST_HELD_MISS;
               on_d    = 1'b0;
               rt_d    = {RT_WIDTH{1'b0}};
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_ARMED: begin
            if (press_s) begin
               state_d = ST_HELD_HIT;
               on_d    = 1'b1;
               rt_d    = rt_cnt_q;
            end else if (!target_up) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_ARMED;
            end
         end
         ST_HELD_HIT: begin
            if (xfer_s) begin
               state_d = ST_LOCKOUT;
            end else begin
               state_d = ST_HELD_HIT;
            end
         end
         ST_HELD_MISS: begin
            if (xfer_s) begin
               state_d = target_up ? ST_ARMED : ST_IDLE;
            end else begin
               state_d = ST_HELD_MISS;
            end
         end
         ST_LOCKOUT: begin
            if (!target_up) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_LOCKOUT;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      valid_d = (state_d == ST_HELD_HIT) | (state_d == ST_HELD_MISS);
   end

   // State, registered result outputs, target history and reaction counter.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= ST_IDLE;
         valid_q  <= 1'b0;
         on_q     <= 1'b0;
         rt_q     <= {RT_WIDTH{1'b0}};
         target_q <= 1'b0;
         rt_cnt_q <= {RT_WIDTH{1'b0}};
      end else begin
         state_q  <= state_d;
         valid_q  <= valid_d;
         on_q     <= on_d;
         rt_q     <= rt_d;
         target_q <= target_up;
         rt_cnt_q <= rt_cnt_d;
      end
   end

   assign hit_valid     = valid_q;
   assign hit_on_target = on_q;
   assign hit_rt        = rt_q;

`ifdef MISS_COUNT_EN
   logic       miss_load_s;
   logic [7:0] miss_cnt_q;

   assign miss_load_s = (state_q == ST_IDLE) & ~t_rise_s & press_s & ~target_up;

   // Count loaded miss results (dropped presses do not count), saturating at 255.
   always_ff @(posedge clk) begin
      if (reset) begin
         miss_cnt_q <= 8'd0;
      end else if (miss_load_s && (miss_cnt_q != 8'hFF)) begin
         miss_cnt_q <= miss_cnt_q + 8'd1;
      end else begin
         miss_cnt_q <= miss_cnt_q;
      end
   end

   assign miss_count = miss_cnt_q;
`endif

endmodule
